// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler feeding a single UART transmitter, with baud-change handshake.
// Optional even parity bit between data and stop when UART_TX_SCHED_PARITY_EN is defined.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      baud_tick,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      cfg_valid,
  input  logic [1:0]                cfg_sel_baud,
  output logic                      cfg_ready,
  output logic [1:0]                sel_baud,
  output logic                      tx,
  output logic                      busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);
  localparam logic [PtrW-1:0] LastReq = PtrW'(NUM_REQ - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StSettle} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BitW-1:0]     bit_idx_q, bit_idx_d;
  logic                settle_q, settle_d;
  logic [1:0]          cfg_hold_q, cfg_hold_d;
  logic [1:0]          sel_baud_q, sel_baud_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  // Round-robin search starting at ptr_q.
  logic                found;
  logic [PtrW-1:0]     win;
  logic [PtrW:0]       sum;
  logic [DATA_W-1:0]   win_data;

  always_comb begin
    found    = 1'b0;
    win      = '0;
    sum      = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (sum >= (PtrW+1)'(NUM_REQ)) sum = sum - (PtrW+1)'(NUM_REQ);
      if (!found && req[sum[PtrW-1:0]]) begin
        found = 1'b1;
        win   = sum[PtrW-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PtrW'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    bit_idx_d   = bit_idx_q;
    settle_d    = settle_q;
    cfg_hold_d  = cfg_hold_q;
    gnt_d       = '0;
    cfg_ready_d = 1'b0;
    // The accepted code lands on sel_baud one clk after the cfg_ready pulse.
    sel_baud_d  = cfg_ready_q ? cfg_hold_q : sel_baud_q;

    case (state_q)
      StIdle: begin
        if (baud_tick) begin
          if (cfg_valid) begin
            cfg_ready_d = 1'b1;
            cfg_hold_d  = cfg_sel_baud;
            settle_d    = 1'b0;
            state_d     = StSettle;
          end else if (found) begin
            gnt_d[win] = 1'b1;
            data_d     = win_data;
            ptr_d      = (win == LastReq) ? '0 : win + 1'b1;
            bit_idx_d  = '0;
            state_d    = StStart;
          end
        end
      end
      StStart: begin
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_tick) begin
          if (bit_idx_q == LastBit) begin
`ifdef UART_TX_SCHED_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_SCHED_PARITY_EN
      StParity: begin
        if (baud_tick) state_d = StStop;
      end
`endif
      StStop: begin
        if (baud_tick) state_d = StIdle;
      end
      StSettle: begin
        if (baud_tick) begin
          if (settle_q) state_d = StIdle;
          else          settle_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered, so it follows the state being entered.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[bit_idx_d];
`ifdef UART_TX_SCHED_PARITY_EN
      StParity: tx_d = ^data_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      data_q      <= '0;
      bit_idx_q   <= '0;
      settle_q    <= 1'b0;
      cfg_hold_q  <= 2'b00;
      sel_baud_q  <= 2'b00;
      gnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      bit_idx_q   <= bit_idx_d;
      settle_q    <= settle_d;
      cfg_hold_q  <= cfg_hold_d;
      sel_baud_q  <= sel_baud_d;
      gnt_q       <= gnt_d;
      cfg_ready_q <= cfg_ready_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign cfg_ready = cfg_ready_q;
  assign sel_baud  = sel_baud_q;
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: framing, round-robin order, baud-change handshake, reset.
// Define UART_TX_SCHED_PARITY_EN for both DUT and bench to exercise the parity frame.
module tb_uart_tx_scheduler;

`ifdef UART_TX_SCHED_PARITY_EN
  localparam int FL = 11;
  localparam logic [FL-1:0] ExpA5 = 11'b10101001010;
  localparam logic [FL-1:0] Exp07 = 11'b11000001110;
`else
  localparam int FL = 10;
  localparam logic [FL-1:0] ExpA5 = 10'b1101001010;
  localparam logic [FL-1:0] Exp07 = 10'b1000001110;
`endif

  logic        clk;
  logic        reset;
  logic        baud_tick;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        cfg_valid;
  logic [1:0]  cfg_sel_baud;
  logic        cfg_ready;
  logic [1:0]  sel_baud;
  logic        tx;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  uart_tx_scheduler #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .baud_tick    (baud_tick),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .cfg_valid    (cfg_valid),
    .cfg_sel_baud (cfg_sel_baud),
    .cfg_ready    (cfg_ready),
    .sel_baud     (sel_baud),
    .tx           (tx),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk baud_tick every 16 clk.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (15) @(posedge clk);
      #2 baud_tick = 1'b1;
      @(posedge clk);
      #2 baud_tick = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int bound, output int cyc, output logic [3:0] g);
    int i;
    i   = 0;
    cyc = -1;
    g   = 4'b0000;
    while (cyc < 0 && i < bound) begin
      step();
      i++;
      if (gnt !== 4'b0000) begin
        cyc = i;
        g   = gnt;
      end
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy !== 1'b0 && i < 400) begin
      step();
      i++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_data = '0; cfg_valid = 1'b0; cfg_sel_baud = 2'b00;
    repeat (3) step();
    n_vec++;
    if (tx !== 1'b1 || gnt !== 4'b0 || cfg_ready !== 1'b0 || busy !== 1'b0 || sel_baud !== 2'b00)
    begin
      n_bad++;
      $display("FAIL reset: tx=%b gnt=%b cfg_ready=%b busy=%b sel_baud=%b want 1 0000 0 0 00",
               tx, gnt, cfg_ready, busy, sel_baud);
    end
    reset = 1'b0;
  endtask

  task automatic test_frame(input logic [7:0] b, input logic [FL-1:0] exp, input string name);
    int         cyc;
    logic [3:0] g;
    logic       bad;
    req_data       = '0;
    req_data[7:0]  = b;
    req            = 4'b0001;
    wait_gnt(40, cyc, g);
    n_vec++;
    if (g !== 4'b0001) begin
      n_bad++;
      $display("FAIL %s gnt: got %b want 0001", name, g);
    end
    // Byte must already be captured; later changes are ignored.
    req           = 4'b0000;
    req_data[7:0] = ~b;
    bad = 1'b0;
    for (int c = 0; c < FL*16; c++) begin
      if (c > 0) step();
      if (c % 16 == 0) bad = 1'b0;
      if (tx !== exp[c/16] || busy !== 1'b1 || (c > 0 && gnt !== 4'b0000)) bad = 1'b1;
      if (c % 16 == 15) begin
        n_vec++;
        if (bad) begin
          n_bad++;
          $display("FAIL %s bit %0d: tx=%b busy=%b gnt=%b want tx=%b busy=1 gnt=0000",
                   name, c/16, tx, busy, gnt, exp[c/16]);
        end
      end
    end
    step();
    n_vec++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_bad++;
      $display("FAIL %s end: busy=%b tx=%b want 0 1", name, busy, tx);
    end
  endtask

  task automatic test_round_robin();
    int         cyc;
    logic [3:0] g;
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1;
    step();
    reset    = 1'b0;
    req_data = 32'h44332211;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(FL*16 + 40, cyc, g);
      n_vec++;
      if (g !== order[k]) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got %b want %b", k, g, order[k]);
      end
      if (k > 0) begin
        n_vec++;
        if (cyc != (FL+1)*16) begin
          n_bad++;
          $display("FAIL rr_gap[%0d]: got %0d clk want %0d", k, cyc, (FL+1)*16);
        end
      end
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_cfg_during_frame();
    int         cyc;
    int         i;
    logic [3:0] g;
    req_data = 32'h000000C3;
    req      = 4'b0001;
    wait_gnt(40, cyc, g);
    n_vec++;
    if (g !== 4'b0001) begin
      n_bad++;
      $display("FAIL cfg_frame_gnt: got %b want 0001", g);
    end
    req          = 4'b0000;
    cfg_valid    = 1'b1;
    cfg_sel_baud = 2'b11;
    i   = 0;
    cyc = -1;
    while (cyc < 0 && i < (FL+3)*16) begin
      step();
      i++;
      if (cfg_ready === 1'b1) cyc = i;
    end
    n_vec++;
    if (cyc != (FL+1)*16 || sel_baud !== 2'b00 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_ready_timing: at %0d clk sel_baud=%b busy=%b want %0d clk 00 1",
               cyc, sel_baud, busy, (FL+1)*16);
    end
    cfg_valid = 1'b0;
    req       = 4'b0001;
    step();
    n_vec++;
    if (sel_baud !== 2'b11 || cfg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_sel_load: sel_baud=%b cfg_ready=%b want 11 0", sel_baud, cfg_ready);
    end
    // SETTLE spans two ticks; the grant lands on the third tick after acceptance.
    wait_gnt(80, cyc, g);
    n_vec++;
    if (cyc != 47 || g !== 4'b0001) begin
      n_bad++;
      $display("FAIL cfg_settle_gnt: got %b at %0d clk want 0001 at 47", g, cyc);
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_cfg_priority();
    int         cyc;
    int         i;
    logic [3:0] g;
    logic [3:0] early;
    req_data     = 32'h00550000;
    cfg_valid    = 1'b1;
    cfg_sel_baud = 2'b01;
    req          = 4'b0100;
    i     = 0;
    cyc   = -1;
    early = 4'b0000;
    while (cyc < 0 && i < 40) begin
      step();
      i++;
      early = early | gnt;
      if (cfg_ready === 1'b1) cyc = i;
    end
    n_vec++;
    if (cyc < 0 || early !== 4'b0000) begin
      n_bad++;
      $display("FAIL cfg_priority: cfg_ready at %0d gnt seen %b want ready and 0000", cyc, early);
    end
    cfg_valid = 1'b0;
    step();
    n_vec++;
    if (sel_baud !== 2'b01) begin
      n_bad++;
      $display("FAIL cfg_priority_sel: sel_baud=%b want 01", sel_baud);
    end
    wait_gnt(80, cyc, g);
    n_vec++;
    if (cyc != 47 || g !== 4'b0100) begin
      n_bad++;
      $display("FAIL cfg_priority_gnt: got %b at %0d clk want 0100 at 47", g, cyc);
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    int         cyc;
    logic [3:0] g;
    logic       seen;
    req_data = 32'h00003C00;
    req      = 4'b0010;
    wait_gnt(40, cyc, g);
    n_vec++;
    if (g !== 4'b0010) begin
      n_bad++;
      $display("FAIL rst_frame_gnt: got %b want 0010", g);
    end
    req = 4'b0000;
    repeat (70) step();
    n_vec++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_data_bit3: tx=%b busy=%b want 1 1", tx, busy);
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || sel_baud !== 2'b00 || gnt !== 4'b0 || cfg_ready !== 1'b0)
    begin
      n_bad++;
      $display("FAIL rst_mid_frame: tx=%b busy=%b sel_baud=%b gnt=%b cfg_ready=%b want 1 0 00 0000 0",
               tx, busy, sel_baud, gnt, cfg_ready);
    end
    // Reset held across a tick must dominate req and cfg_valid.
    req       = 4'b1111;
    cfg_valid = 1'b1;
    seen      = 1'b0;
    repeat (20) begin
      step();
      if (busy !== 1'b0 || gnt !== 4'b0 || cfg_ready !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_bad++;
      $display("FAIL rst_priority: activity seen=%b want 0", seen);
    end
    reset     = 1'b0;
    cfg_valid = 1'b0;
    req       = 4'b1010;
    wait_gnt(40, cyc, g);
    n_vec++;
    if (g !== 4'b0010) begin
      n_bad++;
      $display("FAIL rst_ptr: got %b want 0010", g);
    end
    req = 4'b0000;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, ExpA5, "frame_a5");
    test_round_robin();
    test_cfg_during_frame();
    test_cfg_priority();
    test_reset_mid_frame();
    test_frame(8'h07, Exp07, "frame_07");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
